dlx_data_mem_if: RTL

Data-side memory interface for the uDLX core, downstream of the core's data port (`data_rd_en`, `data_wr_en`, `data_addr`, `data_write`, `data_read`). It decodes each access into an external synchronous single-port data SRAM, a memory-mapped I/O block, or an unmapped region. The I/O block holds a cycle counter, GPIO, and a compare timer with interrupt. Every read returns on `data_read` exactly one cycle after the request, matching the core's MEM/WB timing.

---
 rtl/dlx_data_mem_if.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dlx_data_mem_if.sv
// dlx_data_mem_if: decodes uDLX data-port accesses into external SRAM, memory-mapped
// IO (cycle counter, GPIO, compare timer) or unmapped space; reads return next cycle.
module dlx_data_mem_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH  = 12,
  parameter int GPIO_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  logic [DATA_WIDTH-1:0]      ram_rdata,
  input  logic [GPIO_WIDTH-1:0]      gpio_in,
  output logic [GPIO_WIDTH-1:0]      gpio_out,
  output logic                       irq
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_IO   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic [2:0] OFF_CYCLE    = 3'd0;
  localparam logic [2:0] OFF_GPIO_OUT = 3'd1;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd2;
  localparam logic [2:0] OFF_TCMP     = 3'd3;
  localparam logic [2:0] OFF_TCNT     = 3'd4;
  localparam logic [2:0] OFF_CTRL     = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_IO  = 4'hF;

  logic [3:0] region;
  logic [2:0] ioOff;
  logic       isRam;
  logic       isIo;
  logic       isUnmapped;
  logic       anyReq;
  logic       conflict;
  logic       ioWr;
  logic       unusedAddrBits;

  logic [DATA_WIDTH-1:0] cycleCnt_q, cycleCnt_d;
  logic [GPIO_WIDTH-1:0] gpioOut_q, gpioOut_d;
  logic [GPIO_WIDTH-1:0] gpioMeta_q;
  logic [GPIO_WIDTH-1:0] gpioSync_q;
  logic [DATA_WIDTH-1:0] tcmp_q, tcmp_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  match_q, match_d;
  logic                  err_q, err_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] ioRdata_q, ioRdata_d;

  logic [1:0] statusClr;
  logic       timerMatch;
  logic       errSet;

  assign region     = data_addr[DATA_ADDR_WIDTH-1 -: 4];
  assign ioOff      = data_addr[4:2];
  assign isRam      = (region == REGION_RAM);
  assign isIo       = (region == REGION_IO);
  assign isUnmapped = !isRam && !isIo;
  assign anyReq     = data_rd_en | data_wr_en;
  assign conflict   = data_rd_en & data_wr_en;
  assign ioWr       = data_wr_en & isIo;

  // Byte-lane bits and the address bits between the SRAM index and region are don't-care.
  assign unusedAddrBits = ^{data_addr[1:0], data_addr[DATA_ADDR_WIDTH-5:RAM_ADDR_WIDTH+2]};

  assign ram_en    = anyReq & isRam & ~rst;
  assign ram_we    = data_wr_en & isRam & ~rst;
  assign ram_addr  = data_addr[RAM_ADDR_WIDTH+1:2];
  assign ram_wdata = data_write;

  assign gpio_out = gpioOut_q;
  assign irq      = match_q & ctrl_q[2];

  always_comb begin
    ioRdata_d = '0;
    case (ioOff)
      OFF_CYCLE:    ioRdata_d = cycleCnt_q;
      OFF_GPIO_OUT: ioRdata_d = DATA_WIDTH'(gpioOut_q);
      OFF_GPIO_IN:  ioRdata_d = DATA_WIDTH'(gpioSync_q);
      OFF_TCMP:     ioRdata_d = tcmp_q;
      OFF_TCNT:     ioRdata_d = tcnt_q;
      OFF_CTRL:     ioRdata_d = DATA_WIDTH'(ctrl_q);
      OFF_STATUS:   ioRdata_d = DATA_WIDTH'({err_q, match_q});
      default:      ioRdata_d = '0;
    endcase
  end

  // A simultaneous read+write is served as a write, so its read slot returns zero.
  always_comb begin
    sel_d = SEL_NONE;
    if (conflict) begin
      sel_d = SEL_ZERO;
    end else if (data_rd_en) begin
      if (isRam)     sel_d = SEL_RAM;
      else if (isIo) sel_d = SEL_IO;
      else           sel_d = SEL_ZERO;
    end
  end

  always_comb begin
    gpioOut_d = gpioOut_q;
    tcmp_d    = tcmp_q;
    ctrl_d    = ctrl_q;
    statusClr = 2'b00;
    if (ioWr) begin
      case (ioOff)
        OFF_GPIO_OUT: gpioOut_d = data_write[GPIO_WIDTH-1:0];
        OFF_TCMP:     tcmp_d    = data_write;
        OFF_CTRL:     ctrl_d    = data_write[2:0];
        OFF_STATUS:   statusClr = data_write[1:0];
        default:      ;
      endcase
    end
  end

  // Timer: a software load beats both auto-reload and the increment.
  always_comb begin
    timerMatch = ctrl_q[0] && (tcnt_q == tcmp_q);
    tcnt_d     = tcnt_q;
    if (ioWr && (ioOff == OFF_TCNT)) begin
      tcnt_d = data_write;
    end else if (timerMatch && ctrl_q[1]) begin
      tcnt_d = '0;
    end else if (ctrl_q[0]) begin
      tcnt_d = tcnt_q + DATA_WIDTH'(1);
    end
  end

  // Sticky status bits: a new event in the same cycle outranks write-1-to-clear.
  always_comb begin
    errSet     = conflict | (anyReq & isUnmapped);
    match_d    = timerMatch | (match_q & ~statusClr[0]);
    err_d      = errSet | (err_q & ~statusClr[1]);
    cycleCnt_d = cycleCnt_q + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt_q <= '0;
      gpioOut_q  <= '0;
      gpioMeta_q <= '0;
      gpioSync_q <= '0;
      tcmp_q     <= '1;
      tcnt_q     <= '0;
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= SEL_NONE;
      ioRdata_q  <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_d;
      gpioOut_q  <= gpioOut_d;
      gpioMeta_q <= gpio_in;
      gpioSync_q <= gpioMeta_q;
      tcmp_q     <= tcmp_d;
      tcnt_q     <= tcnt_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      ioRdata_q  <= ioRdata_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM: data_read = ram_rdata;
      SEL_IO:  data_read = ioRdata_q;
      default: data_read = '0;
    endcase
  end

endmodule
